// File: rtl/serial_mult_dispatcher.sv
`timescale 1ns/1ps
// Issue stage for the serial multiplier: operand FIFO, one-op-at-a-time
// issue with a stale-valid guard cycle, registered result port and timeout.
module serial_mult_dispatcher #(
    parameter int width   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_a,
    input  logic [width-1:0]           in_b,
    output logic                       mul_en,
    output logic [width-1:0]           mul_A,
    output logic [width-1:0]           mul_B,
    input  logic                       mul_valid,
    input  logic [2*width-1:0]         mul_S,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [2*width-1:0]         res_data,
    output logic                       timeout,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [2*width-1:0]   mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mul_en_q, mul_en_d;
    logic [width-1:0]     a_q, a_d, b_q, b_d;
    logic                 res_valid_q, res_valid_d;
    logic [2*width-1:0]   res_data_q, res_data_d;
    logic                 timeout_q, timeout_d;
    logic [TW-1:0]        wcnt_q, wcnt_d;
    logic                 full, empty, push, pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign push  = in_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_en_d    = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        timeout_d   = timeout_q;
        wcnt_d      = wcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    {a_d, b_d} = mem_q[rd_ptr_q];
                    mul_en_d   = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: begin
                // mul_valid may still be high from the previous product here
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_valid) begin
                    res_data_d  = mul_S;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mul_en_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            timeout_q   <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            mul_en_q    <= mul_en_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            timeout_q   <= timeout_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign in_ready  = !full;
    assign mul_en    = mul_en_q;
    assign mul_A     = a_q;
    assign mul_B     = b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign timeout   = timeout_q;
    assign fifo_cnt  = cnt_q;

endmodule

// File: tb/tb_serial_mult_dispatcher.sv
`timescale 1ns/1ps
// Randomized bench for serial_mult_dispatcher with a behavioural
// multiplier, consumer and an a*b result queue as reference.
module tb_serial_mult_dispatcher;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a, in_b;
    logic            mul_en;
    logic [W-1:0]    mul_A, mul_B;
    logic            mul_valid;
    logic [2*W-1:0]  mul_S;
    logic            res_valid;
    logic            res_ready;
    logic [2*W-1:0]  res_data;
    logic            timeout;
    logic [$clog2(D):0] fifo_cnt;

    serial_mult_dispatcher #(.width(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mul_en(mul_en), .mul_A(mul_A), .mul_B(mul_B),
        .mul_valid(mul_valid), .mul_S(mul_S),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .timeout(timeout),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int unsigned exp_q[$];
    int unsigned got_q[$];
    int en_count = 0;
    int push_cyc = 0, en_cyc = 0;
    int dead_en_cyc = -1, to_rise_cyc = -1;
    bit prev_en = 0, prev_to = 0;
    bit saw_full = 0;
    int max_cnt = 0;

    int lat_min = 0, lat_max = 8;
    bit hold_stale = 0;
    bit dead_next = 0;
    int ready_mode = 0;

    // scoreboard: results must equal a*b of accepted pairs, in order
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_en = 0;
            prev_to = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(in_a) * 32'(in_b));
                push_cyc = cyc;
            end
            if (!in_ready) saw_full = 1;
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (res_valid && res_ready) begin
                got_q.push_back(32'(res_data));
                if (exp_q.size() == 0) chk("res_unexp", exp_q.size(), 1);
                else chk("res_data", res_data, exp_q.pop_front());
            end
            if (mul_en) begin
                en_count++;
                en_cyc = cyc;
                if (prev_en) chk("en_width", prev_en, 0);
            end
            if (timeout && !prev_to) begin
                to_rise_cyc = cyc;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_en = mul_en;
            prev_to = timeout;
        end
    end

    // multiplier model: variable latency, optional stale valid, optional hang
    initial begin
        bit en, pend, dead;
        logic [W-1:0] ca, cb;
        int lcnt;
        pend = 0; dead = 0; lcnt = 0; ca = '0; cb = '0;
        mul_valid = 1'b0;
        mul_S = '0;
        forever begin
            @(negedge clk);
            en = mul_en;
            if (en) begin ca = mul_A; cb = mul_B; end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend = 0;
                mul_valid = 1'b0;
                dead_next = 0;
            end else if (en) begin
                pend = 1;
                lcnt = int'($urandom_range(lat_max, lat_min));
                dead = dead_next;
                if (dead_next) dead_en_cyc = cyc;
                dead_next = 0;
                if (!hold_stale) mul_valid = 1'b0;
            end else if (pend) begin
                if (lcnt > 0) begin
                    mul_valid = 1'b0;
                    lcnt--;
                end else if (!dead) begin
                    chk("opA_hold", mul_A, ca);
                    chk("opB_hold", mul_B, cb);
                    mul_valid = 1'b1;
                    mul_S = 16'(ca) * 16'(cb);
                    pend = 0;
                end else begin
                    mul_valid = 1'b0;
                end
            end else if (!hold_stale) begin
                mul_valid = 1'b0;
            end
        end
    end

    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(1, 0));
                default: res_ready = 1'b0;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        do begin
            @(negedge clk);
            acc = in_ready;
            n++;
        end while (!acc && n < 2000);
        if (!acc) chk("push_timeout", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (fifo_cnt == 0) && !res_valid;
            n++;
        end while (!done && n < 5000);
        if (!done) chk("drain_timeout", done, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned last_got(input int k);
        if (got_q.size() < k) return 32'hFFFF_FFFF;
        return got_q[got_q.size() - k];
    endfunction

    initial begin
        int e0, g0, n;
        logic [2*W-1:0] held;
        bit seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_en", mul_en, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_to", timeout, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_data", res_data, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        e0 = en_count;
        push(13, 11);
        drain();
        chk("t1_res", last_got(1), 143);
        chk("t1_en", en_count - e0, 1);
        chk("t1_lat", en_cyc - push_cyc, 2);
        chk("t1_cnt", fifo_cnt, 0);

        push(255, 255);
        push(0, 200);
        push(1, 255);
        drain();
        chk("t2_ff", last_got(3), 65025);
        chk("t2_zero", last_got(2), 0);
        chk("t2_one", last_got(1), 255);

        ready_mode = 2;
        lat_min = 20;
        lat_max = 20;
        saw_full = 0;
        max_cnt = 0;
        for (int i = 0; i < 5; i++) push(W'(i + 3), W'(2 * i + 5));
        @(negedge clk);
        chk("t3_full", in_ready, 0);
        chk("t3_cnt", fifo_cnt, 4);
        @(posedge clk);
        #1;
        fork
            push(17, 19);
            begin
                tick(40);
                ready_mode = 0;
            end
        join
        drain();
        chk("t3_sawfull", saw_full, 1);
        chk("t3_max", max_cnt, 4);
        chk("t3_last", last_got(1), 323);

        lat_min = 0;
        lat_max = 8;
        ready_mode = 2;
        push(21, 2);
        push(4, 5);
        seen = 0;
        n = 0;
        do begin
            @(negedge clk);
            seen = res_valid;
            n++;
        end while (!seen && n < 500);
        chk("t4_seen", seen, 1);
        held = res_data;
        chk("t4_first", held, 42);
        e0 = en_count;
        repeat (30) begin
            @(negedge clk);
            chk("t4_rv", res_valid, 1);
            chk("t4_data", res_data, held);
        end
        chk("t4_noen", en_count - e0, 0);
        chk("t4_cnt", fifo_cnt, 1);
        @(posedge clk);
        #1;
        ready_mode = 0;
        drain();
        chk("t4_next", en_count - e0, 1);
        chk("t4_res", last_got(1), 20);

        dead_next = 1;
        push(3, 3);
        push(7, 9);
        drain();
        chk("t5_to", timeout, 1);
        chk("t5_time", to_rise_cyc - dead_en_cyc, TO + 2);
        chk("t5_res", last_got(1), 63);

        lat_min = 20;
        lat_max = 20;
        for (int i = 0; i < 4; i++) push(W'(10 + i), W'(10 + i));
        tick(2);
        chk("t6_cnt_pre", fifo_cnt, 3);
        rst_n = 1'b0;
        #2;
        chk("t6_cnt", fifo_cnt, 0);
        chk("t6_en", mul_en, 0);
        chk("t6_A", mul_A, 0);
        chk("t6_B", mul_B, 0);
        chk("t6_rv", res_valid, 0);
        chk("t6_data", res_data, 0);
        chk("t6_to", timeout, 0);
        tick(2);
        rst_n = 1'b1;
        lat_min = 0;
        lat_max = 8;
        e0 = en_count;
        tick(5);
        chk("t6_noen", en_count - e0, 0);
        chk("t6_norv", res_valid, 0);
        push(100, 3);
        drain();
        chk("t6_res", last_got(1), 300);

        ready_mode = 1;
        lat_max = 10;
        g0 = got_q.size();
        for (int i = 0; i < 50; i++) begin
            hold_stale = 1'($urandom_range(1, 0));
            push(W'($urandom), W'($urandom));
            tick(int'($urandom_range(3, 1)));
        end
        drain();
        chk("t7_count", got_q.size() - g0, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
        $fatal(1);
    end

endmodule
